// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command sequencer and its datapath.
// Op codes, FSM states and error result constants.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  localparam logic [15:0] RES_DIV0 = 16'hFFFF;
  localparam logic [15:0] RES_TMO  = 16'h0000;

  function automatic logic is_multi(op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-side signals of the sequencer.
// master = sequencer side, slave = host/ALU environment side.
interface alu_cmd_sequencer_if #(
  parameter int TAG_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [1:0]       alu_op_sel;
  logic             alu_load;
  logic [15:0]      alu_result;
  logic             alu_done;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    output cmd_ready,
    output rsp_valid, rsp_result, rsp_tag, rsp_err,
    input  rsp_ready,
    output alu_a, alu_b, alu_op_sel, alu_load,
    input  alu_result, alu_done
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    input  cmd_ready,
    input  rsp_valid, rsp_result, rsp_tag, rsp_err,
    output rsp_ready,
    input  alu_a, alu_b, alu_op_sel, alu_load,
    output alu_result, alu_done
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count and full/empty flags.
// DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to the ALU
// and returns tagged results over a valid/ready response port.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int ADDSUB_LAT = 1,
  parameter int TIMEOUT    = 64
) (
  input logic               clk,
  input logic               reset_n,
  alu_cmd_sequencer_if.master bus
);

  localparam int W    = 18 + TAG_W;
  localparam int CMAX = (TIMEOUT > ADDSUB_LAT) ? TIMEOUT : ADDSUB_LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(ADDSUB_LAT - 1);
  localparam logic [CW-1:0] TMO_M1 = CW'(TIMEOUT - 1);

  logic [W-1:0]     head;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic             rdy_q;

  logic [7:0]       h_a, h_b;
  logic [TAG_W-1:0] h_tag;
  op_e              h_op;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      res_q, res_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic             err_q, err_d;

  logic start, div0, start_div0, start_alu;
  logic multi, fin_ok, fin_tmo;

  // Ready is held low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  assign bus.cmd_ready = rdy_q & ~fifo_full;
  assign push          = bus.cmd_valid & bus.cmd_ready;

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .wdata ({bus.cmd_tag, bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign h_tag = head[W-1:18];
  assign h_op  = op_e'(head[17:16]);
  assign h_a   = head[15:8];
  assign h_b   = head[7:0];

  assign start      = (state_q == S_IDLE) & ~fifo_empty;
  assign div0       = (h_op == OP_DIV) & (h_b == 8'h00);
  assign start_div0 = start & div0;
  assign start_alu  = start & ~div0;
  assign pop        = start;

  assign multi   = is_multi(op_q);
  assign fin_ok  = (state_q == S_WAIT) &
                   (multi ? bus.alu_done : (cnt_q == LAT_M1));
  assign fin_tmo = (state_q == S_WAIT) & multi &
                   ~bus.alu_done & (cnt_q == TMO_M1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = div0 ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (fin_ok || fin_tmo) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.alu_load  = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      S_ISSUE: bus.alu_load  = 1'b1;
      S_RESP:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    tag_d  = tag_q;
    res_d  = res_q;
    rtag_d = rtag_q;
    err_d  = err_q;
    cnt_d  = (state_q == S_WAIT) ? cnt_q + CW'(1) : '0;
    unique case (1'b1)
      start_div0: begin
        res_d  = RES_DIV0;
        rtag_d = h_tag;
        err_d  = 1'b1;
      end
      start_alu: begin
        op_d  = h_op;
        a_d   = h_a;
        b_d   = h_b;
        tag_d = h_tag;
      end
      fin_ok: begin
        res_d  = bus.alu_result;
        rtag_d = tag_q;
        err_d  = 1'b0;
        cnt_d  = '0;
      end
      fin_tmo: begin
        res_d  = RES_TMO;
        rtag_d = tag_q;
        err_d  = 1'b1;
        cnt_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      rtag_q <= '0;
      err_q  <= 1'b0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      rtag_q <= rtag_d;
      err_q  <= err_d;
    end
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op_sel = op_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_tag    = rtag_q;
  assign bus.rsp_err    = err_q;

endmodule
